alu_cond_unit: RTL and testbench
================================

# alu_cond_unit

Consumer side of the ALU flags interface. It holds the architectural flags register that the ALU flag generator writes, and keeps it coherent with in-flight flag-writing ALU ops through a pending-op counter. It evaluates branch condition codes against the register using a valid/ready handshake, and provides a 4-deep flags save/restore stack for interrupt entry and return. It sits between the ALU flag outputs and the sequencer's branch logic.

## Interface
- No parameters (stack depth 4, pending counter max 3 are fixed).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flags_in  in  8  flag vector from ALU: [0] zero, [1] carry, [2] equal, [3] lesser, [4] greater, [7:5] reserved
- flags_we  in  1  write flags_in into flags register this edge
- alu_issue  in  1  a flag-writing ALU op was issued this cycle
- issue_ready  out  1  pending count < 3; sequencer must not assert alu_issue when low
- cond_valid  in  1  branch condition request
- cond_code  in  4  condition selector
- cond_ready  out  1  request accepted when cond_valid & cond_ready
- res_valid  out  1  one-cycle pulse, result of accepted request
- res_take  out  1  condition true (branch taken); valid with res_valid
- res_illegal  out  1  reserved cond_code; valid with res_valid
- flags_push  in  1  save flags_q onto stack
- flags_pop  in  1  restore top of stack into flags register
- stack_empty  out  1  stack holds 0 entries
- stack_full  out  1  stack holds 4 entries
- stack_err  out  1  sticky: push on full or pop on empty
- flags_q  out  8  current flags register

## Operation
- Flags register: bits [7:5] always stored as 0 regardless of flags_in.
- Register update priority per edge: flags_pop (valid, non-empty, without push) > flags_we > hold. A flags_we that loses to a pop is dropped.
- Pending counter (2 bits): +1 on alu_issue, -1 on flags_we, unchanged when both are asserted or neither is. A flags_we at count 0 does not decrement. An alu_issue at count 3 is ignored and sets stack_err. Popping does not change the count.
- cond_ready = (pending == 0). Requests therefore never see stale flags.
- Evaluation uses flags_q as it is in the accept cycle, before any same-edge write.
- Condition codes:
  - 0 always; 1 never
  - 2 Z; 3 !Z; 4 C; 5 !C
  - 6 EQ; 7 !EQ
  - 8 LT; 9 !LT; 10 GT; 11 !GT
  - 12 Z&!C; 13 C|Z
  - 14, 15 reserved: res_take=0, res_illegal=1
- Stack: LIFO of 4 entries, pointer 0..4.
  - Push stores flags_q (pre-edge value).
  - Push when full: ignored, stack_err set.
  - Pop when empty: ignored, stack_err set. flags_we still applies that cycle.
  - Push and pop in the same cycle: both ignored, no error. flags_we still applies.
  - Stack contents are not cleared by reset; only the pointer is.
- stack_err is cleared only by rst.

## Timing
- Reset values: flags_q=0x00, pending=0, pointer=0, stack_empty=1, stack_full=0, stack_err=0, res_valid=0, res_take=0, res_illegal=0, cond_ready=1, issue_ready=1.
- flags_we at edge N: flags_q reflects the new value after edge N.
- Request accepted at edge N: res_valid=1 in cycle N+1 only. res_take and res_illegal are held until the next result.
- Back-to-back requests: one accept per cycle is allowed, giving a continuous res_valid.
- alu_issue at edge N: cond_ready goes low in cycle N+1.
- Final flags_we (count 1 -> 0) at edge M: cond_ready goes high in cycle M+1. The first accepted request sees the new flags.
- Mid-operation rst: the pending result is discarded and res_valid=0 on the next cycle.
- All outputs are registered except cond_ready and issue_ready, which decode registered state combinationally.

## Test plan
- Reset, then flags_we with flags_in=0xFF, then cond_code=2 -> flags_q=0x1F; res_valid one cycle after accept with res_take=1.
- Stall: alu_issue, 2 idle cycles, then flags_we with 0x01, while cond_valid=1 code 3 throughout -> accept only in the cycle after the write; res_take=0.
- Sweep codes 0-15 with flags_q=0x0A (C, LT) -> take for codes 0, 3, 4, 7, 8, 11, 13; codes 14 and 15 give res_illegal=1.
- Push 0x01, 0x02, 0x04, 0x08; push again -> stack_full=1 and stack_err=1. Then 4 pops -> flags_q sequence 0x08, 0x04, 0x02, 0x01, then stack_empty=1.
- Pop concurrent with flags_we=0x10 while stack top is 0x03 -> flags_q=0x03. Pop on empty with flags_we=0x10 -> flags_q=0x10 and stack_err=1.
- Three alu_issue cycles -> issue_ready=0. A fourth alu_issue -> stack_err=1, count stays 3. rst in the middle of this sequence -> all reset values restored next cycle.

Source files
------------

// File: rtl/alu_cond_unit.sv
// Architectural flags register with pending-op interlock, branch condition
// evaluation over a valid/ready handshake, and a 4-deep flags save/restore stack.
module alu_cond_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flags_in,
    input  logic       flags_we,
    input  logic       alu_issue,
    output logic       issue_ready,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       res_valid,
    output logic       res_take,
    output logic       res_illegal,
    input  logic       flags_push,
    input  logic       flags_pop,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err,
    output logic [7:0] flags_q
);

    localparam int unsigned FLAG_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);
    localparam logic [FLAG_W-1:0] FLAG_MASK = FLAG_W'(8'h1F);

    logic [FLAG_W-1:0] stack_mem [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic [FLAG_W-1:0] flags_d;
    logic              err_d;
    logic              do_push, do_pop, issue_eff;
    logic [IDX_W-1:0]  top_idx;
    logic              accept;
    logic              take_c, illegal_c;
    logic              f_z, f_c, f_eq, f_lt, f_gt;

    assign issue_ready = (pend_q != CNT_MAX);
    assign cond_ready  = (pend_q == '0);
    assign accept      = cond_valid & cond_ready;

    // Next-state for flags register, stack pointer, pending counter, error flag
    always_comb begin
        ptr_d     = ptr_q;
        pend_d    = pend_q;
        flags_d   = flags_q;
        err_d     = stack_err;
        top_idx   = IDX_W'(ptr_q - PTR_W'(1));
        do_push   = flags_push & ~flags_pop & (ptr_q != PTR_W'(DEPTH));
        do_pop    = flags_pop & ~flags_push & (ptr_q != '0);
        issue_eff = alu_issue & (pend_q != CNT_MAX);

        if (flags_push & ~flags_pop & (ptr_q == PTR_W'(DEPTH))) err_d = 1'b1;
        if (flags_pop & ~flags_push & (ptr_q == '0))            err_d = 1'b1;
        if (alu_issue & (pend_q == CNT_MAX))                    err_d = 1'b1;

        if (do_push) ptr_d = ptr_q + PTR_W'(1);
        if (do_pop)  ptr_d = ptr_q - PTR_W'(1);

        if (do_pop)        flags_d = stack_mem[top_idx];
        else if (flags_we) flags_d = flags_in & FLAG_MASK;

        case ({issue_eff, flags_we})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   if (pend_q != '0) pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    // Condition decode against the pre-edge flags
    always_comb begin
        f_z       = flags_q[0];
        f_c       = flags_q[1];
        f_eq      = flags_q[2];
        f_lt      = flags_q[3];
        f_gt      = flags_q[4];
        take_c    = 1'b0;
        illegal_c = 1'b0;
        case (cond_code)
            4'd0:    take_c = 1'b1;
            4'd1:    take_c = 1'b0;
            4'd2:    take_c = f_z;
            4'd3:    take_c = ~f_z;
            4'd4:    take_c = f_c;
            4'd5:    take_c = ~f_c;
            4'd6:    take_c = f_eq;
            4'd7:    take_c = ~f_eq;
            4'd8:    take_c = f_lt;
            4'd9:    take_c = ~f_lt;
            4'd10:   take_c = f_gt;
            4'd11:   take_c = ~f_gt;
            4'd12:   take_c = f_z & ~f_c;
            4'd13:   take_c = f_c | f_z;
            default: illegal_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            ptr_q       <= '0;
            pend_q      <= '0;
            stack_err   <= 1'b0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            res_valid   <= 1'b0;
            res_take    <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            stack_err   <= err_d;
            stack_empty <= (ptr_d == '0);
            stack_full  <= (ptr_d == PTR_W'(DEPTH));
            res_valid   <= accept;
            if (accept) begin
                res_take    <= take_c;
                res_illegal <= illegal_c;
            end
        end
    end

    // Stack storage survives reset; only the pointer is cleared
    always_ff @(posedge clk) begin
        if (!rst && do_push) stack_mem[ptr_q[IDX_W-1:0]] <= flags_q;
    end

endmodule

// File: tb/tb_alu_cond_unit.sv
// Directed bench for alu_cond_unit: flags write, interlock stall, condition
// sweep, save/restore stack and pending-counter limits with reset.
module tb_alu_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] flags_in;
    logic       flags_we, alu_issue, cond_valid, flags_push, flags_pop;
    logic [3:0] cond_code;
    logic       issue_ready, cond_ready, res_valid, res_take, res_illegal;
    logic       stack_empty, stack_full, stack_err;
    logic [7:0] flags_q;

    int tests_run = 0;
    int tests_failed = 0;

    alu_cond_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flags_in   (flags_in),
        .flags_we   (flags_we),
        .alu_issue  (alu_issue),
        .issue_ready(issue_ready),
        .cond_valid (cond_valid),
        .cond_code  (cond_code),
        .cond_ready (cond_ready),
        .res_valid  (res_valid),
        .res_take   (res_take),
        .res_illegal(res_illegal),
        .flags_push (flags_push),
        .flags_pop  (flags_pop),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"},  flags_q, 8'h00);
        check({tag, "_empty"},  8'(stack_empty), 8'd1);
        check({tag, "_full"},   8'(stack_full), 8'd0);
        check({tag, "_err"},    8'(stack_err), 8'd0);
        check({tag, "_rvalid"}, 8'(res_valid), 8'd0);
        check({tag, "_take"},   8'(res_take), 8'd0);
        check({tag, "_ill"},    8'(res_illegal), 8'd0);
        check({tag, "_cready"}, 8'(cond_ready), 8'd1);
        check({tag, "_iready"}, 8'(issue_ready), 8'd1);
    endtask

    logic [7:0] push_vals [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    logic [15:0] take_0a = 16'b0010_1001_1001_1001;

    initial begin
        rst = 1'b1; flags_in = '0; flags_we = 0; alu_issue = 0;
        cond_valid = 0; cond_code = '0; flags_push = 0; flags_pop = 0;
        step(); step();
        rst = 1'b0;
        check_reset_state("rst0");

        // Write all-ones, reserved bits must stay clear
        flags_in = 8'hFF; flags_we = 1; step(); flags_we = 0;
        check("we_ff", flags_q, 8'h1F);
        cond_valid = 1; cond_code = 4'd2; step(); cond_valid = 0;
        check("z_valid", 8'(res_valid), 8'd1);
        check("z_take", 8'(res_take), 8'd1);
        check("z_ill", 8'(res_illegal), 8'd0);
        step();
        check("z_pulse", 8'(res_valid), 8'd0);
        check("z_hold", 8'(res_take), 8'd1);

        // Interlock stall: request held while an op is in flight
        alu_issue = 1; step(); alu_issue = 0;
        cond_valid = 1; cond_code = 4'd3;
        check("stall_cr0", 8'(cond_ready), 8'd0);
        step();
        check("stall_rv1", 8'(res_valid), 8'd0);
        step();
        check("stall_rv2", 8'(res_valid), 8'd0);
        flags_in = 8'h01; flags_we = 1; step(); flags_we = 0;
        check("stall_rv3", 8'(res_valid), 8'd0);
        check("stall_cr1", 8'(cond_ready), 8'd1);
        check("stall_flags", flags_q, 8'h01);
        step(); cond_valid = 0;
        check("stall_rv4", 8'(res_valid), 8'd1);
        check("stall_take", 8'(res_take), 8'd0);
        step();

        // Back-to-back sweep of all codes with C and LT set
        flags_in = 8'h0A; flags_we = 1; step(); flags_we = 0;
        for (int i = 0; i < 16; i++) begin
            cond_valid = 1; cond_code = 4'(i); step();
            check($sformatf("sw%0d_rv", i), 8'(res_valid), 8'd1);
            check($sformatf("sw%0d_take", i), 8'(res_take), 8'(take_0a[i]));
            check($sformatf("sw%0d_ill", i), 8'(res_illegal), (i >= 14) ? 8'd1 : 8'd0);
        end
        cond_valid = 0; step();
        check("sw_end", 8'(res_valid), 8'd0);

        // Fill the stack, overflow, then drain
        for (int i = 0; i < 4; i++) begin
            flags_in = push_vals[i]; flags_we = 1; step(); flags_we = 0;
            flags_push = 1; step(); flags_push = 0;
        end
        check("fill_full", 8'(stack_full), 8'd1);
        check("fill_err", 8'(stack_err), 8'd0);
        flags_push = 1; step(); flags_push = 0;
        check("ovf_full", 8'(stack_full), 8'd1);
        check("ovf_err", 8'(stack_err), 8'd1);
        for (int i = 3; i >= 0; i--) begin
            flags_pop = 1; step(); flags_pop = 0;
            check($sformatf("pop%0d", i), flags_q, push_vals[i]);
        end
        check("drain_empty", 8'(stack_empty), 8'd1);

        // Pop beats flags_we; pop on empty lets flags_we through
        rst = 1; step(); rst = 0;
        check("rst1_err", 8'(stack_err), 8'd0);
        flags_in = 8'h03; flags_we = 1; step(); flags_we = 0;
        flags_push = 1; step(); flags_push = 0;
        flags_in = 8'h10; flags_we = 1; flags_pop = 1; step();
        check("popwe_flags", flags_q, 8'h03);
        check("popwe_err", 8'(stack_err), 8'd0);
        step(); flags_we = 0; flags_pop = 0;
        check("popempty_flags", flags_q, 8'h10);
        check("popempty_err", 8'(stack_err), 8'd1);

        // Pending counter saturation
        rst = 1; step(); rst = 0;
        alu_issue = 1;
        step(); step(); step();
        check("pend3_iready", 8'(issue_ready), 8'd0);
        check("pend3_err", 8'(stack_err), 8'd0);
        step(); alu_issue = 0;
        check("pend4_err", 8'(stack_err), 8'd1);
        check("pend4_iready", 8'(issue_ready), 8'd0);
        flags_in = 8'h00; flags_we = 1; step(); flags_we = 0;
        check("pend2_iready", 8'(issue_ready), 8'd1);
        check("pend2_cready", 8'(cond_ready), 8'd0);

        // Reset mid-sequence with activity on inputs
        alu_issue = 1; cond_valid = 1; cond_code = 4'd0; flags_push = 1; rst = 1;
        step();
        rst = 0; alu_issue = 0; cond_valid = 0; flags_push = 0;
        check_reset_state("rst2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
